// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display scan controller.
//   - state_e       : scan FSM state encoding (IDLE/LOAD/SHOW/BLANK)
//   - NIBBLE_W      : width of one digit value fed to the segment decoder
//   - DIGITS_OFF    : all-ones digit-enable vector (every digit dark), sized
//                     for the largest supported channel count; slice it down
//   - DEF_DWELL/DEF_BLANK : default on-time and blanking time in cycles
// -----------------------------------------------------------------------------
package display_pkg;

   localparam int NIBBLE_W  = 4;
   localparam int MAX_CH    = 8;
   localparam int DEF_DWELL = 50000;
   localparam int DEF_BLANK = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHOW  = 2'd2,
      ST_BLANK = 2'd3
   } state_e;

   // Active-low enables: all ones means no digit is lit.
   localparam logic [MAX_CH-1:0] DIGITS_OFF = '1;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches req starting at ptr,
// then ptr+1, ... wrapping from N-1 back to 0, and grants the first set bit.
// Ports:
//   req       in  N    request vector
//   ptr       in  PW   index with highest priority this round
//   grant     out N    one-hot grant (all zero when no request)
//   grant_idx out PW   binary index of the granted request (0 when none)
//   any_req   out 1    at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          any_req
);

   always_comb begin
      logic found;
      int   j;
      found     = 1'b0;
      j         = 0;
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      for (int i = 0; i < N; i++) begin
         // Rotate the search so ptr has top priority; wrap without a modulo.
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexes one shared segment decoder across NUM_CH digit sources.
// Each slot: LOAD (1 cycle, latch winner + ack), SHOW (DWELL cycles, one
// digit lit), BLANK (BLANK cycles, all digits dark), then re-arbitrate.
//
// Handshake: ch_valid[i] is a level request; the controller takes
// ch_data[i] on the edge that enters LOAD, and ch_ack[i] pulses for exactly
// that LOAD cycle. A requester that keeps ch_valid high is re-served every
// time round-robin reaches it; data sampled at LOAD is frozen until the next
// LOAD, so later changes to ch_valid/ch_data never disturb the shown digit.
//
// Ports:
//   Clock      in  1          system clock, rising edge
//   Resetn     in  1          synchronous active-low reset
//   ch_valid   in  NUM_CH     channel has a value to show
//   ch_data    in  4*NUM_CH   channel i nibble at [4i+3:4i]
//   ch_ack     out NUM_CH     one-cycle pulse, channel data latched
//   dec_in     out 4          nibble to shared decoder
//   dig_en_n   out NUM_CH     active-low digit enables, at most one low
//   busy       out 1          high in LOAD/SHOW/BLANK
//   fsm_state  out 2          current scan state (state_e encoding)
// All outputs are registered.
// -----------------------------------------------------------------------------
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DWELL  = DEF_DWELL,
   parameter int BLANK  = DEF_BLANK
) (
   input  logic                       Clock,
   input  logic                       Resetn,
   input  logic [NUM_CH-1:0]          ch_valid,
   input  logic [NIBBLE_W*NUM_CH-1:0] ch_data,
   output logic [NUM_CH-1:0]          ch_ack,
   output logic [NIBBLE_W-1:0]        dec_in,
   output logic [NUM_CH-1:0]          dig_en_n,
   output logic                       busy,
   output logic [1:0]                 fsm_state
);

   localparam int PW = $clog2(NUM_CH);
   localparam int DW = $clog2(DWELL + 1);
   // A zero-length blank still needs a legal (unused) counter.
   localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK > 0) ? BLANK - 1 : 0);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_LOAD  = ST_LOAD;
   localparam logic [1:0] S_SHOW  = ST_SHOW;
   localparam logic [1:0] S_BLANK = ST_BLANK;

   localparam logic [NUM_CH-1:0] OFF_VEC = DIGITS_OFF[NUM_CH-1:0];
   localparam logic [NUM_CH-1:0] ONE_VEC = NUM_CH'(1);
   localparam logic [PW-1:0]     LAST_CH = PW'(NUM_CH - 1);

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       rr_ptr_nxt;
   logic [PW-1:0]       g_q;
   logic [NIBBLE_W-1:0] data_q;
   logic [DW-1:0]       dwell_cnt;
   logic [BW-1:0]       blank_cnt;

   logic [NUM_CH-1:0]   grant;
   logic [PW-1:0]       grant_idx;
   logic                any_req;

   rr_arbiter #(
      .N  (NUM_CH),
      .PW (PW)
   ) u_arb (
      .req       (ch_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   assign rr_ptr_nxt = (grant_idx == LAST_CH) ? '0 : grant_idx + PW'(1);
   assign fsm_state  = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (dwell_cnt == DWELL_LAST) begin
               if (BLANK > 0) state_d = S_BLANK;
               else           state_d = any_req ? S_LOAD : S_IDLE;
            end
         end
         S_BLANK: begin
            if (blank_cnt == BLANK_LAST) state_d = any_req ? S_LOAD : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from state_d so their registered values line up
   // with state_q in the same cycle.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q   <= S_IDLE;
         rr_ptr    <= '0;
         g_q       <= '0;
         data_q    <= '0;
         dwell_cnt <= '0;
         blank_cnt <= '0;
         ch_ack    <= '0;
         dec_in    <= '0;
         dig_en_n  <= OFF_VEC;
         busy      <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != S_IDLE);
         ch_ack  <= '0;

         // Arbitration result is captured on the edge entering LOAD.
         if (state_d == S_LOAD) begin
            g_q    <= grant_idx;
            data_q <= ch_data[{grant_idx, 2'b00} +: NIBBLE_W];
            rr_ptr <= rr_ptr_nxt;
            ch_ack <= grant;
         end

         if (state_d == S_SHOW) begin
            dig_en_n <= ~(ONE_VEC << g_q);
            dec_in   <= data_q;
         end else begin
            dig_en_n <= OFF_VEC;
         end

         if (state_q == S_SHOW && state_d == S_SHOW) dwell_cnt <= dwell_cnt + DW'(1);
         else                                        dwell_cnt <= '0;

         if (state_q == S_BLANK && state_d == S_BLANK) blank_cnt <= blank_cnt + BW'(1);
         else                                          blank_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl with NUM_CH=4, DWELL=4, BLANK=2.
// Each expected slot {ack[3:0], dig_en_n[3:0], dec_in[3:0]} is queued when
// the stimulus is set up and popped when the DUT acknowledges a channel.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

   localparam int NUM_CH = 4;
   localparam int DWELL  = 4;
   localparam int BLANK  = 2;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic [3:0]  ch_valid = '0;
   logic [15:0] ch_data = '0;
   logic [3:0]  ch_ack;
   logic [3:0]  dec_in;
   logic [3:0]  dig_en_n;
   logic        busy;
   logic [1:0]  fsm_state;

   int n_chk  = 0;
   int n_fail = 0;
   logic [11:0] exp_q[$];

   display_scan_ctrl #(
      .NUM_CH (NUM_CH),
      .DWELL  (DWELL),
      .BLANK  (BLANK)
   ) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .ch_valid  (ch_valid),
      .ch_data   (ch_data),
      .ch_ack    (ch_ack),
      .dec_in    (dec_in),
      .dig_en_n  (dig_en_n),
      .busy      (busy),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   always #5 Clock = ~Clock;

   // ---------------- driver / checker tasks ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dig_en_n"}, 16'(dig_en_n), 16'hF);
      chk({tag, "_dec_in"},   16'(dec_in),   16'h0);
      chk({tag, "_ch_ack"},   16'(ch_ack),   16'h0);
      chk({tag, "_busy"},     16'(busy),     16'h0);
      chk({tag, "_state"},    16'(fsm_state), 16'h0);
   endtask

   // Waits (bounded) for the next ack, pops the expected slot and checks the
   // LOAD cycle, DWELL show cycles and BLANK blank cycles. Optional hooks:
   // change channel 2 data at show cycle chg_k, drop all valids in the first
   // blank cycle, or assert reset in show cycle 1 and return.
   task automatic expect_slot(input int chg_k, input logic [3:0] chg_val,
                              input bit drop, input bit rst_mid, output int waited);
      logic [11:0] e;
      waited = 0;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 16'(exp_q.size()), 16'h1);
         return;
      end
      e = exp_q.pop_front();
      while (ch_ack == 4'b0 && waited < 20) begin
         tick();
         waited++;
      end
      chk("load_ack",     16'(ch_ack),   16'(e[11:8]));
      chk("load_busy",    16'(busy),     16'h1);
      chk("load_dig_off", 16'(dig_en_n), 16'hF);
      tick();
      for (int k = 0; k < DWELL; k++) begin
         chk("show_dig_en_n", 16'(dig_en_n), 16'(e[7:4]));
         chk("show_dec_in",   16'(dec_in),   16'(e[3:0]));
         chk("show_ack_low",  16'(ch_ack),   16'h0);
         if (k == chg_k) ch_data[11:8] = chg_val;
         if (rst_mid && k == 1) begin
            Resetn = 1'b0;
            return;
         end
         tick();
      end
      for (int k = 0; k < BLANK; k++) begin
         chk("blank_dig_off", 16'(dig_en_n), 16'hF);
         chk("blank_dec_in",  16'(dec_in),   16'(e[3:0]));
         chk("blank_busy",    16'(busy),     16'h1);
         if (drop && k == 0) ch_valid = 4'b0000;
         tick();
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int w;

      // Reset
      Resetn   = 1'b0;
      ch_valid = 4'b0000;
      ch_data  = 16'h0000;
      tick();
      tick();
      check_reset_outputs("reset");
      Resetn = 1'b1;
      tick();
      tick();
      chk("idle_no_req_busy",  16'(busy),     16'h0);
      chk("idle_no_req_state", 16'(fsm_state), 16'h0);
      chk("idle_no_req_dig",   16'(dig_en_n), 16'hF);

      // Round-robin over four requesters, data 1,2,3,4
      ch_data = 16'h4321;
      exp_q.push_back({4'b0001, 4'b1110, 4'h1});
      exp_q.push_back({4'b0010, 4'b1101, 4'h2});
      exp_q.push_back({4'b0100, 4'b1011, 4'h3});
      exp_q.push_back({4'b1000, 4'b0111, 4'h4});
      exp_q.push_back({4'b0001, 4'b1110, 4'h1});
      ch_valid = 4'b1111;
      expect_slot(-1, 4'h0, 1'b0, 1'b0, w);
      chk("rr_first_latency", 16'(w), 16'h1);
      for (int s = 0; s < 4; s++) begin
         expect_slot(-1, 4'h0, 1'b0, 1'b0, w);
         chk("rr_slot_7_cycles", 16'(w), 16'h0);
      end

      // Reset mid-SHOW while channel 1 is lit; pointer must restart at 0
      exp_q.push_back({4'b0010, 4'b1101, 4'h2});
      expect_slot(-1, 4'h0, 1'b0, 1'b1, w);
      chk("pre_reset_slot_gap", 16'(w), 16'h0);
      tick();
      check_reset_outputs("mid_show_reset");
      tick();
      Resetn = 1'b1;
      exp_q.push_back({4'b0001, 4'b1110, 4'h1});
      expect_slot(-1, 4'h0, 1'b1, 1'b0, w);
      chk("post_reset_latency", 16'(w), 16'h1);

      // Valid dropped during BLANK: back to IDLE
      chk("drop_idle_state", 16'(fsm_state), 16'h0);
      chk("drop_idle_busy",  16'(busy),      16'h0);
      chk("drop_idle_dig",   16'(dig_en_n),  16'hF);
      tick();
      chk("drop_idle_ack",   16'(ch_ack),    16'h0);
      chk("drop_idle_busy2", 16'(busy),      16'h0);

      // Single channel 2 with value 9, re-latched each slot; data changes
      // 9->5 at show cycle 2 of the third slot, fourth slot shows 5.
      ch_data = 16'h0900;
      exp_q.push_back({4'b0100, 4'b1011, 4'h9});
      exp_q.push_back({4'b0100, 4'b1011, 4'h9});
      exp_q.push_back({4'b0100, 4'b1011, 4'h9});
      exp_q.push_back({4'b0100, 4'b1011, 4'h5});
      ch_valid = 4'b0100;
      expect_slot(-1, 4'h0, 1'b0, 1'b0, w);
      chk("single_latency", 16'(w), 16'h1);
      expect_slot(-1, 4'h0, 1'b0, 1'b0, w);
      chk("single_repeat_gap", 16'(w), 16'h0);
      expect_slot(2, 4'h5, 1'b0, 1'b0, w);
      chk("single_change_gap", 16'(w), 16'h0);
      expect_slot(-1, 4'h0, 1'b1, 1'b0, w);
      chk("single_new_data_gap", 16'(w), 16'h0);
      chk("final_idle_state", 16'(fsm_state), 16'h0);
      chk("final_idle_busy",  16'(busy),      16'h0);
      chk("final_idle_dig",   16'(dig_en_n),  16'hF);
      chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Hard stop in case something above stalls.
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=stalled expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
